// File: rtl/dc_ctrl_pkg.sv
// rtl/dc_ctrl_pkg.sv - shared encodings for the data-memory controller, SLB and arbiter
package dc_ctrl_pkg;

    localparam int DC_NICK_W = 4;
    localparam int DC_ADDR_W = 32;
    localparam int DC_DATA_W = 32;

    localparam logic [1:0] LEN_ONE  = 2'b00;
    localparam logic [1:0] LEN_TWO  = 2'b01;
    localparam logic [1:0] LEN_FOUR = 2'b11;

    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } dc_state_t;

    // Byte count for a size code; the unused code 10 behaves as a single byte.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_ONE:  len_bytes = 3'd1;
            LEN_TWO:  len_bytes = 3'd2;
            LEN_FOUR: len_bytes = 3'd4;
            default:  len_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dc_ctrl_byte_asm.sv
// rtl/dc_ctrl_byte_asm.sv - byte-lane assembly register, zero-filled at start of each access
module dc_byte_asm
    import dc_ctrl_pkg::*;
#(
    parameter int DATA_W = DC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              start,
    input  logic              cap,
    input  logic [1:0]        lane,
    input  logic [7:0]        din,
    output logic [DATA_W-1:0] word_nxt
);

    logic [DATA_W-1:0] word;

    // Next word: cleared on a new access, then one lane overwritten per captured byte.
    always_comb begin
        word_nxt = word;
        if (start) begin
            word_nxt = '0;
        end
        if (cap) begin
            word_nxt[{lane, 3'b000} +: 8] = din;
        end
    end

    // Assembly register, frozen by the global stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else if (rdy) begin
            word <= word_nxt;
        end
    end

endmodule

// File: rtl/dc_ctrl.sv
// rtl/dc_ctrl.sv - serializes SLB loads/stores into byte accesses on the shared RAM port
module dc_ctrl
    import dc_ctrl_pkg::*;
#(
    parameter int NICK_W = DC_NICK_W,
    parameter int ADDR_W = DC_ADDR_W,
    parameter int DATA_W = DC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iSLB_en,
    input  logic              iSLB_ls,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [1:0]        iSLB_len,
    input  logic [ADDR_W-1:0] iSLB_addr,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oSLB_busy,
    output logic              oSLB_en,
    output logic [NICK_W-1:0] oSLB_nick,
    output logic [DATA_W-1:0] oSLB_dt,
    output logic              oMEM_req,
    input  logic              iMEM_gnt,
    output logic [ADDR_W-1:0] oMEM_a,
    output logic              oMEM_wr,
    output logic [7:0]        oMEM_dout,
    input  logic [7:0]        iMEM_din
);

    dc_state_t         state, state_nxt;
    logic              ls_q;
    logic [NICK_W-1:0] nick_q;
    logic [2:0]        n_q;
    logic [2:0]        k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dt_q;
    logic              en_q;
    logic [DATA_W-1:0] word_nxt;

    logic is_load;
    logic abort;
    logic accept;
    logic last_wr;
    logic last_cap;
    logic cap;

    assign is_load  = (ls_q == LS_LOAD);
    // Stores are committed once accepted, so only loads can be flushed.
    assign abort    = clr && is_load && (state != ST_IDLE);
    assign accept   = (state == ST_IDLE) && iSLB_en && !clr;
    assign last_wr  = (k_q == n_q - 3'd1);
    // Read data lags the address by one cycle, so a load runs one slot past its last byte.
    assign last_cap = (k_q == n_q);
    assign cap      = (state == ST_XFER) && is_load && (k_q != 3'd0);

    // The response pulse is suppressed in the very cycle a flush arrives.
    assign oSLB_en  = en_q && !clr;

    // State register; a low rdy holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next state and RAM-port outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        oSLB_busy = (state != ST_IDLE);
        oMEM_req  = 1'b0;
        oMEM_a    = '0;
        oMEM_wr   = 1'b0;
        oMEM_dout = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                oMEM_req = !abort;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (iMEM_gnt) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                oMEM_req = !abort;
                oMEM_a   = addr_q + ADDR_W'(k_q);
                if (!is_load) begin
                    oMEM_wr   = rdy;
                    oMEM_dout = dt_q[{k_q[1:0], 3'b000} +: 8];
                end
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (is_load ? last_cap : last_wr) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, byte index and load response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ls_q      <= LS_LOAD;
            nick_q    <= '0;
            n_q       <= 3'd0;
            k_q       <= 3'd0;
            addr_q    <= '0;
            dt_q      <= '0;
            en_q      <= 1'b0;
            oSLB_nick <= '0;
            oSLB_dt   <= '0;
        end else if (rdy) begin
            en_q <= 1'b0;
            if (accept) begin
                ls_q   <= iSLB_ls;
                nick_q <= iSLB_nick;
                n_q    <= len_bytes(iSLB_len);
                addr_q <= iSLB_addr;
                dt_q   <= iSLB_dt;
            end
            if (state == ST_XFER) begin
                k_q <= k_q + 3'd1;
            end else begin
                k_q <= 3'd0;
            end
            if ((state == ST_XFER) && is_load && !clr && last_cap) begin
                en_q      <= 1'b1;
                oSLB_dt   <= word_nxt;
                oSLB_nick <= nick_q;
            end
        end
    end

    dc_byte_asm #(
        .DATA_W (DATA_W)
    ) u_byte_asm (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .start    (accept),
        .cap      (cap),
        .lane     (2'(k_q - 3'd1)),
        .din      (iMEM_din),
        .word_nxt (word_nxt)
    );

endmodule

// File: tb/tb_dc_ctrl.sv
// tb/tb_dc_ctrl.sv - scoreboard bench for dc_ctrl
module tb_dc_ctrl;
    import dc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        iSLB_en = 1'b0;
    logic        iSLB_ls = 1'b0;
    logic [3:0]  iSLB_nick = '0;
    logic [1:0]  iSLB_len = '0;
    logic [31:0] iSLB_addr = '0;
    logic [31:0] iSLB_dt = '0;
    logic        oSLB_busy, oSLB_en, oMEM_req, oMEM_wr;
    logic [3:0]  oSLB_nick;
    logic [31:0] oSLB_dt, oMEM_a;
    logic [7:0]  oMEM_dout;
    logic [7:0]  iMEM_din = '0;
    logic        iMEM_gnt;

    typedef struct { logic [3:0] nick; logic [31:0] dt; int cyc; } ld_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

    ld_t  ldq[$];
    wr_t  wq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   gnt_delay = 0;
    int   gcnt = 0;
    int   exp_idle = 0;
    logic [7:0] ram [0:4095];

    dc_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .iSLB_en(iSLB_en), .iSLB_ls(iSLB_ls), .iSLB_nick(iSLB_nick),
        .iSLB_len(iSLB_len), .iSLB_addr(iSLB_addr), .iSLB_dt(iSLB_dt),
        .oSLB_busy(oSLB_busy), .oSLB_en(oSLB_en), .oSLB_nick(oSLB_nick), .oSLB_dt(oSLB_dt),
        .oMEM_req(oMEM_req), .iMEM_gnt(iMEM_gnt), .oMEM_a(oMEM_a), .oMEM_wr(oMEM_wr),
        .oMEM_dout(oMEM_dout), .iMEM_din(iMEM_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Byte RAM: registered read, frozen with the rest of the machine while rdy is low.
    always @(posedge clk) begin
        if (rdy) iMEM_din <= ram[oMEM_a[11:0]];
        if (oMEM_wr) ram[oMEM_a[11:0]] = oMEM_dout;
    end

    // Arbiter: grants gnt_delay cycles after the request and holds until it drops.
    always @(posedge clk) begin
        if (!oMEM_req) gcnt <= 0;
        else if (rdy && gcnt < gnt_delay) gcnt <= gcnt + 1;
    end
    assign iMEM_gnt = oMEM_req && (gcnt >= gnt_delay);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        if (len == 2'b11) return 4;
        if (len == 2'b01) return 2;
        return 1;
    endfunction

    // Monitor: pops the scoreboards on load responses and RAM writes.
    always begin : monitor
        ld_t e;
        wr_t x;
        @(negedge clk);
        #1;
        if (oSLB_en && rdy) begin
            if (ldq.size() == 0) check("unexp_rsp", 1, 0);
            else begin
                e = ldq.pop_front();
                check("ld_dt", oSLB_dt, e.dt);
                check("ld_nick", oSLB_nick, e.nick);
                check("ld_lat", cyc, e.cyc);
            end
        end
        if (oMEM_wr) begin
            if (wq.size() == 0) check("unexp_wr", 1, 0);
            else begin
                x = wq.pop_front();
                check("wr_a", oMEM_a, x.a);
                check("wr_d", oMEM_dout, x.d);
            end
        end
    end

    task automatic issue(input logic ls, input logic [3:0] nick, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] dt, input bit rsp, input int extra);
        int n;
        logic [31:0] w;
        logic [31:0] ak;
        ld_t e;
        wr_t x;
        n = nbytes(len);
        w = '0;
        check("busy_pre", oSLB_busy, 0);
        for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            if (ls) begin
                x.a = ak; x.d = dt[8*k +: 8];
                wq.push_back(x);
            end else begin
                w[8*k +: 8] = ram[ak[11:0]];
            end
        end
        if (!ls && rsp) begin
            e.nick = nick; e.dt = w; e.cyc = cyc + n + 3 + extra;
            ldq.push_back(e);
        end
        exp_idle = cyc + n + (ls ? 3 : 4) + extra;
        iSLB_en = 1'b1; iSLB_ls = ls; iSLB_nick = nick; iSLB_len = len;
        iSLB_addr = addr; iSLB_dt = dt;
        @(negedge clk);
        iSLB_en = 1'b0;
    endtask

    task automatic wait_idle(input bit chk_lat);
        int i;
        i = 0;
        while (oSLB_busy && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("idle_to", oSLB_busy, 0);
        if (chk_lat) check("idle_lat", cyc, exp_idle);
        @(negedge clk);
        check("ldq_empty", ldq.size(), 0);
        check("wq_empty", wq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'hFFF] = 8'h80; ram[12'h000] = 8'h5A;

        repeat (2) @(negedge clk);
        check("rst_busy", oSLB_busy, 0);
        check("rst_req", oMEM_req, 0);
        check("rst_en", oSLB_en, 0);
        check("rst_dt", oSLB_dt, 0);
        check("rst_a", oMEM_a, 0);
        rst = 1'b1; rdy = 1'b1;
        @(negedge clk);

        issue(1'b0, 4'h3, LEN_FOUR, 32'h100, 32'h0, 1'b1, 0);
        wait_idle(1'b1);
        issue(1'b1, 4'h1, LEN_TWO, 32'h201, 32'hDEADBEEF, 1'b1, 0);
        wait_idle(1'b1);
        check("ram_201", ram[12'h201], 8'hEF);
        check("ram_202", ram[12'h202], 8'hBE);
        issue(1'b0, 4'h4, LEN_FOUR, 32'h200, 32'h0, 1'b1, 0);
        wait_idle(1'b1);
        issue(1'b0, 4'h6, LEN_ONE, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        wait_idle(1'b1);
        issue(1'b0, 4'h7, LEN_TWO, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        wait_idle(1'b1);
        issue(1'b1, 4'h2, LEN_TWO, 32'hFFFFFFFF, 32'h0000A5C3, 1'b1, 0);
        wait_idle(1'b1);
        issue(1'b0, 4'h8, 2'b10, 32'h100, 32'h0, 1'b1, 0);
        wait_idle(1'b1);
        issue(1'b1, 4'h8, 2'b10, 32'h180, 32'h123456E7, 1'b1, 0);
        wait_idle(1'b1);

        gnt_delay = 5;
        issue(1'b0, 4'hA, LEN_FOUR, 32'h100, 32'h0, 1'b1, 5);
        repeat (3) @(negedge clk);
        check("req_wait", oMEM_req, 1);
        wait_idle(1'b1);
        gnt_delay = 0;

        issue(1'b0, 4'h5, LEN_FOUR, 32'h100, 32'h0, 1'b0, 0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_req", oMEM_req, 0);
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", oSLB_busy, 0);
        wait_idle(1'b0);

        issue(1'b1, 4'h5, LEN_FOUR, 32'h240, 32'h0BADF00D, 1'b1, 0);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        wait_idle(1'b1);

        check("busy_pre", oSLB_busy, 0);
        clr = 1'b1; iSLB_en = 1'b1; iSLB_ls = 1'b0; iSLB_len = LEN_FOUR; iSLB_addr = 32'h100;
        @(negedge clk);
        clr = 1'b0; iSLB_en = 1'b0;
        check("clr_idle_drop", oSLB_busy, 0);
        wait_idle(1'b0);

        issue(1'b0, 4'h9, LEN_FOUR, 32'h100, 32'h0, 1'b1, 3);
        @(negedge clk);
        rdy = 1'b0;
        #1;
        check("stall_a", oMEM_a, 32'h100);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("stall_a", oMEM_a, 32'h100);
        end
        @(negedge clk);
        rdy = 1'b1;
        wait_idle(1'b1);

        issue(1'b1, 4'hB, LEN_FOUR, 32'h2C0, 32'h89ABCDEF, 1'b1, 1);
        @(negedge clk);
        rdy = 1'b0;
        #1;
        check("stall_wr", oMEM_wr, 0);
        @(negedge clk);
        rdy = 1'b1;
        wait_idle(1'b1);

        issue(1'b1, 4'hC, LEN_FOUR, 32'h300, 32'hCAFEF00D, 1'b1, 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wr", oMEM_wr, 0);
        check("arst_req", oMEM_req, 0);
        check("arst_busy", oSLB_busy, 0);
        check("arst_a", oMEM_a, 0);
        check("arst_dout", oMEM_dout, 0);
        wq.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_idle(1'b0);

        for (int t = 0; t < 10; t++) begin
            logic [1:0] len;
            len = 2'($urandom_range(0, 3));
            gnt_delay = int'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), len,
                  32'h400 + 32'($urandom_range(0, 64)), $urandom, 1'b1, gnt_delay);
            wait_idle(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
